// File: rtl/kbd_text_ctrl_if.sv
// rtl/kbd_text_ctrl_if.sv - scancode input, ROM lookup and character-RAM write bundle for kbd_text_ctrl
interface kbd_text_ctrl_if;
  logic        key_valid;
  logic [7:0]  key_code;
  logic        key_ready;
  logic [7:0]  rom_addr;
  logic [7:0]  rom_data;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic [4:0]  cur_row;
  logic [6:0]  cur_col;

  modport master (
    output key_valid, key_code, rom_data,
    input  key_ready, rom_addr, wr_en, wr_addr, wr_data, cur_row, cur_col
  );

  modport slave (
    input  key_valid, key_code, rom_data,
    output key_ready, rom_addr, wr_en, wr_addr, wr_data, cur_row, cur_col
  );
endinterface

// File: rtl/kbd_text_ctrl.sv
// rtl/kbd_text_ctrl.sv - PS/2 scancode to character-RAM sequencer with text cursor
// Define KBD_TEXT_CTRL_CLEAR_EN to blank each newly entered row.
module kbd_text_ctrl #(
  parameter int COLS = 70,
  parameter int ROWS = 30
) (
  input  logic           clk,
  input  logic           rst,
  kbd_text_ctrl_if.slave bus
);

  localparam logic [6:0] COL_LAST = 7'(COLS - 1);
  localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SKIP,
    LOOKUP,
    DECODE
`ifdef KBD_TEXT_CTRL_CLEAR_EN
    , CLEAR
`endif
  } state_t;

  state_t      state_q, state_d;
  logic        key_ready_q, key_ready_d;
  logic [7:0]  rom_addr_q, rom_addr_d;
  logic        wr_en_q, wr_en_d;
  logic [11:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [4:0]  row_q, row_d;
  logic [6:0]  col_q, col_d;
`ifdef KBD_TEXT_CTRL_CLEAR_EN
  logic [6:0]  clr_col_q, clr_col_d;
`endif
  logic        accept;
  logic        newline;

  assign accept = bus.key_valid && key_ready_q;

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    row_d      = row_q;
    col_d      = col_q;
`ifdef KBD_TEXT_CTRL_CLEAR_EN
    clr_col_d  = clr_col_q;
`endif
    newline    = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.key_code == 8'hF0) begin
            state_d = SKIP;
          end else if (bus.key_code != 8'hE0) begin
            rom_addr_d = bus.key_code;
            state_d    = LOOKUP;
          end
        end
      end
      SKIP: begin
        if (accept) state_d = IDLE;
      end
      LOOKUP: state_d = DECODE;
      DECODE: begin
        state_d = IDLE;
        case (bus.rom_data)
          8'h00: ;
          8'h0D: newline = 1'b1;
          8'h08: begin
            // Backspace at the home position is silently ignored.
            if (col_q != 7'd0) begin
              col_d     = col_q - 7'd1;
              wr_en_d   = 1'b1;
              wr_addr_d = {row_q, col_q - 7'd1};
              wr_data_d = 8'h20;
            end else if (row_q != 5'd0) begin
              row_d     = row_q - 5'd1;
              col_d     = COL_LAST;
              wr_en_d   = 1'b1;
              wr_addr_d = {row_q - 5'd1, COL_LAST};
              wr_data_d = 8'h20;
            end
          end
          default: begin
            wr_en_d   = 1'b1;
            wr_addr_d = {row_q, col_q};
            wr_data_d = bus.rom_data;
            if (col_q == COL_LAST) newline = 1'b1;
            else                   col_d   = col_q + 7'd1;
          end
        endcase
        if (newline) begin
          col_d = 7'd0;
          row_d = (row_q == ROW_LAST) ? 5'd0 : row_q + 5'd1;
`ifdef KBD_TEXT_CTRL_CLEAR_EN
          state_d   = CLEAR;
          clr_col_d = 7'd0;
`endif
        end
      end
`ifdef KBD_TEXT_CTRL_CLEAR_EN
      CLEAR: begin
        // row_q already points at the new row; the cursor stays at column 0.
        wr_en_d   = 1'b1;
        wr_addr_d = {row_q, clr_col_q};
        wr_data_d = 8'h20;
        clr_col_d = clr_col_q + 7'd1;
        if (clr_col_q == COL_LAST) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase

    key_ready_d = (state_d == IDLE) || (state_d == SKIP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      key_ready_q <= 1'b1;
      rom_addr_q  <= 8'h00;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= 12'h000;
      wr_data_q   <= 8'h00;
      row_q       <= 5'd0;
      col_q       <= 7'd0;
`ifdef KBD_TEXT_CTRL_CLEAR_EN
      clr_col_q   <= 7'd0;
`endif
    end else begin
      state_q     <= state_d;
      key_ready_q <= key_ready_d;
      rom_addr_q  <= rom_addr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      row_q       <= row_d;
      col_q       <= col_d;
`ifdef KBD_TEXT_CTRL_CLEAR_EN
      clr_col_q   <= clr_col_d;
`endif
    end
  end

  assign bus.key_ready = key_ready_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.cur_row   = row_q;
  assign bus.cur_col   = col_q;

endmodule

// File: tb/tb_kbd_text_ctrl.sv
// tb/tb_kbd_text_ctrl.sv - scoreboard bench for kbd_text_ctrl with a cursor reference model
module tb_kbd_text_ctrl;

  localparam int COLS = 70;
  localparam int ROWS = 30;

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  data;
    logic        kr_chk;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] rom [256];
  exp_t exp_q [$];
  int vectors = 0;
  int miscompares = 0;
  int row_m = 0;
  int col_m = 0;

  kbd_text_ctrl_if bus ();

  kbd_text_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.rom_data = rom[bus.rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.wr_en) begin
      exp_t e;
      chk("sb_has_entry", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", {20'd0, bus.wr_addr}, {20'd0, e.addr});
        chk("wr_data", {24'd0, bus.wr_data}, {24'd0, e.data});
        if (e.kr_chk) chk("key_ready_in_clear", {31'd0, bus.key_ready}, 32'd0);
      end
    end
  end

  task automatic push(input int r, input int c, input logic [7:0] d, input logic kr);
    exp_t e;
    e.addr   = {5'(r), 7'(c)};
    e.data   = d;
    e.kr_chk = kr;
    exp_q.push_back(e);
  endtask

  task automatic send_key(input logic [7:0] c);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.key_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("key_ready_wait", {31'd0, n < 500}, 32'd1);
    bus.key_valid = 1'b1;
    bus.key_code  = c;
    @(posedge clk);
    #1 bus.key_valid = 1'b0;
  endtask

  task automatic press(input logic [7:0] c);
    logic [7:0] a;
    logic nl;
    send_key(c);
    a  = rom[c];
    nl = 1'b0;
    if (a == 8'h0D) begin
      nl = 1'b1;
    end else if (a == 8'h08) begin
      if (col_m != 0) begin
        col_m--;
        push(row_m, col_m, 8'h20, 1'b0);
      end else if (row_m != 0) begin
        row_m--;
        col_m = COLS - 1;
        push(row_m, col_m, 8'h20, 1'b0);
      end
    end else if (a != 8'h00) begin
      push(row_m, col_m, a, 1'b0);
      if (col_m == COLS - 1) nl = 1'b1;
      else col_m++;
    end
    if (nl) begin
      col_m = 0;
      row_m = (row_m == ROWS - 1) ? 0 : row_m + 1;
`ifdef KBD_TEXT_CTRL_CLEAR_EN
      for (int k = 0; k < COLS; k++) push(row_m, k, 8'h20, k < COLS - 1);
`endif
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    repeat (3) @(negedge clk);
    while ((exp_q.size() != 0 || !bus.key_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_empty", exp_q.size(), 32'd0);
  endtask

  task automatic chk_cursor(input string tag, input int r, input int c);
    chk({tag, "_row"}, {27'd0, bus.cur_row}, r);
    chk({tag, "_col"}, {25'd0, bus.cur_col}, c);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    row_m = 0;
    col_m = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[8'h1C] = 8'h61;
    rom[8'h32] = 8'h62;
    rom[8'h5A] = 8'h0D;
    rom[8'h66] = 8'h08;
    bus.key_valid = 1'b0;
    bus.key_code  = 8'h00;
    rst = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst_key_ready", {31'd0, bus.key_ready}, 32'd1);
    chk("rst_rom_addr", {24'd0, bus.rom_addr}, 32'h00);
    chk("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
    chk("rst_wr_addr", {20'd0, bus.wr_addr}, 32'h000);
    chk("rst_wr_data", {24'd0, bus.wr_data}, 32'h00);
    chk_cursor("rst", 0, 0);
    rst = 1'b0;

    press(8'h1C);
    @(negedge clk);
    chk("lookup_wr_en", {31'd0, bus.wr_en}, 32'd0);
    chk("lookup_key_ready", {31'd0, bus.key_ready}, 32'd0);
    @(negedge clk);
    chk("decode_wr_en", {31'd0, bus.wr_en}, 32'd0);
    @(negedge clk);
    chk("write_wr_en", {31'd0, bus.wr_en}, 32'd1);
    chk("write_key_ready", {31'd0, bus.key_ready}, 32'd1);
    chk_cursor("first_key", 0, 1);
    drain();

    send_key(8'hF0);
    @(negedge clk);
    chk("skip_key_ready", {31'd0, bus.key_ready}, 32'd1);
    send_key(8'h32);
    drain();
    chk("break_rom_addr", {24'd0, bus.rom_addr}, 32'h1C);
    chk_cursor("break", 0, 1);

    send_key(8'hE0);
    press(8'h1C);
    drain();
    chk_cursor("prefix", 0, 2);

    press(8'h05);
    drain();
    chk_cursor("null_char", 0, 2);

    do_reset();
    for (int i = 0; i < COLS; i++) press(8'h32);
    drain();
    chk_cursor("row_fill", 1, 0);

    press(8'h66);
    drain();
    chk_cursor("bs_wrap", 0, COLS - 1);

    do_reset();
    press(8'h66);
    drain();
    chk_cursor("bs_home", 0, 0);

    for (int i = 0; i < ROWS - 1; i++) press(8'h5A);
    drain();
    chk_cursor("row_last", ROWS - 1, 0);
    press(8'h5A);
    drain();
    chk_cursor("row_wrap", 0, 0);

    press(8'h5A);
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_key_ready", {31'd0, bus.key_ready}, 32'd1);
    chk("abort_wr_en", {31'd0, bus.wr_en}, 32'd0);
    chk("abort_wr_addr", {20'd0, bus.wr_addr}, 32'h000);
    chk_cursor("abort", 0, 0);
    exp_q.delete();
    row_m = 0;
    col_m = 0;
    @(negedge clk);
    rst = 1'b0;

    send_key(8'h32);
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drain();
    chk_cursor("lookup_abort", 0, 0);

    press(8'h1C);
    drain();
    chk_cursor("after_abort", 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
